button_cmd_sequencer: RTL and testbench

BUTTON_CMD_SEQUENCER -- requirements
Module: button_cmd_sequencer

---
 rtl/button_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_button_cmd_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_sequencer.sv
// Debounces five raw buttons and turns presses (plus auto-repeat on the
// direction keys) into at most one valid/ready command per video frame.
module button_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_FRAMES   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] io_button,
  input  logic       frame_tick,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_code,
  output logic [4:0] btn_level,
  output logic       busy
);

  localparam int DB_W      = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int RP_W      = ($clog2(REPEAT_FRAMES + 1) < 1) ? 1 : $clog2(REPEAT_FRAMES + 1);
  localparam int RP_LAST_I = (REPEAT_FRAMES > 0) ? REPEAT_FRAMES - 1 : 0;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST     = RP_W'(RP_LAST_I);
  localparam logic [4:0]      REPEAT_MASK = 5'b11101;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_UP     = 3'd1;
  localparam logic [2:0] CMD_DOWN   = 3'd2;
  localparam logic [2:0] CMD_LEFT   = 3'd3;
  localparam logic [2:0] CMD_RIGHT  = 3'd4;
  localparam logic [2:0] CMD_SELECT = 3'd5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ISSUE      = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [4:0]      sync_a, sync_b;
  logic [4:0]      level_q;
  logic [DB_W-1:0] db_cnt [5];
  logic [RP_W-1:0] rp_cnt [5];
  logic [4:0]      press, rep_hit, grant, pend;
  logic            valid_next;
  logic [2:0]      code_next;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= io_button;
      sync_b <= sync_a;
    end
  end

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  // NOTE: the counters are plain flops, not a RAM, so each element is reset
  // explicitly; a RAM-style array would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      btn_level <= '0;
      level_q   <= '0;
    end else begin
      level_q <= btn_level;
      for (int i = 0; i < 5; i++) begin
        if (sync_b[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= ~btn_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = btn_level & ~level_q;

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < 5; i++) begin
      if (REPEAT_FRAMES > 0 && REPEAT_MASK[i] && btn_level[i] && frame_tick &&
          rp_cnt[i] == RP_LAST)
        rep_hit[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) rp_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!btn_level[i] || !REPEAT_MASK[i])
          rp_cnt[i] <= '0;
        else if (rep_hit[i])
          rp_cnt[i] <= '0;
        else if (frame_tick && rp_cnt[i] != RP_LAST)
          rp_cnt[i] <= rp_cnt[i] + 1'b1;
      end
    end
  end

  // A new press or repeat on the bit being granted wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~grant) | press | rep_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NONE;
    end else begin
      state     <= state_next;
      cmd_valid <= valid_next;
      cmd_code  <= code_next;
    end
  end

  always_comb begin
    state_next = state;
    valid_next = cmd_valid;
    code_next  = cmd_code;
    grant      = '0;
    case (state)
      IDLE: begin
        if (|pend) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_tick && |pend) begin
          state_next = ISSUE;
          valid_next = 1'b1;
          if (pend[1]) begin
            grant = 5'b00010; code_next = CMD_SELECT;
          end else if (pend[0]) begin
            grant = 5'b00001; code_next = CMD_UP;
          end else if (pend[2]) begin
            grant = 5'b00100; code_next = CMD_DOWN;
          end else if (pend[3]) begin
            grant = 5'b01000; code_next = CMD_LEFT;
          end else begin
            grant = 5'b10000; code_next = CMD_RIGHT;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          code_next  = CMD_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_button_cmd_sequencer.sv
// Bench for button_cmd_sequencer: directed scenarios plus random button
// traffic, every cycle compared against a behavioural reference model.
module tb_button_cmd_sequencer;
  localparam int DB = 4;
  localparam int RF = 3;
  localparam int FP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] io_button = '0;
  logic       frame_tick = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] btn_level;
  logic       busy;

  button_cmd_sequencer #(.DEBOUNCE_CYCLES(DB), .REPEAT_FRAMES(RF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_button (io_button),
    .frame_tick(frame_tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .btn_level (btn_level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames = 0;
  int hs = 0;
  logic [2:0] hs_code [$];
  int         hs_frame [$];

  // Reference model: raw history, mismatch run lengths, frames held,
  // a pending set, and the command currently being presented.
  logic [4:0] raw_hist [$];
  logic [4:0] m_level, m_pend, m_rose;
  int         m_run [5];
  int         m_held [5];
  int         m_phase;   // 0 quiet, 1 waiting for a frame, 2 presenting
  logic [2:0] m_cmd;

  function automatic logic [2:0] code_of(input int b);
    case (b)
      0: return 3'd1;
      1: return 3'd5;
      2: return 3'd2;
      3: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  task automatic model_reset();
    raw_hist.delete();
    m_level = '0; m_pend = '0; m_rose = '0;
    m_phase = 0; m_cmd = '0;
    for (int i = 0; i < 5; i++) begin
      m_run[i] = 0; m_held[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [4:0] raw, input logic tick, input logic rdy);
    logic [4:0] set_m, clr, synced;
    int order [5];
    bit found;
    order = '{1, 0, 2, 3, 4};
    set_m = m_rose;
    clr = '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) continue;
      if (!m_level[i]) m_held[i] = 0;
      else if (tick) begin
        m_held[i]++;
        if (m_held[i] == RF) begin
          set_m[i] = 1'b1;
          m_held[i] = 0;
        end
      end
    end
    if (m_phase == 1) begin
      if (tick) begin
        found = 0;
        for (int k = 0; k < 5; k++) begin
          if (!found && m_pend[order[k]]) begin
            found = 1;
            clr[order[k]] = 1'b1;
            m_cmd = code_of(order[k]);
            m_phase = 2;
          end
        end
      end
    end else if (m_phase == 2) begin
      if (rdy) begin
        m_cmd = '0;
        m_phase = 0;
      end
    end else if (m_pend != 0) begin
      m_phase = 1;
    end
    m_pend = (m_pend & ~clr) | set_m;
    synced = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'b0;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    m_rose = '0;
    for (int i = 0; i < 5; i++) begin
      if (synced[i] == m_level[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_run[i] = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) m_rose[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [4:0] btn, input logic rdy);
    logic [9:0] exp_v, got_v;
    io_button  = btn;
    cmd_ready  = rdy;
    frame_tick = ((cyc + 1) % FP == 0);
    if (rst_n && cmd_valid && rdy) begin
      hs++;
      hs_code.push_back(cmd_code);
      hs_frame.push_back(frames);
    end
    @(posedge clk);
    cyc++;
    if (frame_tick) frames++;
    if (rst_n) model_edge(btn, frame_tick, rdy);
    #1;
    exp_v = {m_phase == 2, m_cmd, m_phase != 0, m_level};
    got_v = {cmd_valid, cmd_code, busy, btn_level};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL model cycle %0d: {valid,code,busy,level} got %b want %b", cyc, got_v, exp_v);
    end
  endtask

  task automatic align();
    while (cyc % FP != 0) step(5'b0, 1'b1);
  endtask

  task automatic test_reset();
    int n0;
    io_button = 5'b00001;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_valid, cmd_code, busy, btn_level} !== 10'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 0", {cmd_valid, cmd_code, busy, btn_level});
    end
    #3 rst_n = 1'b1;
    n0 = hs;
    for (int k = 0; k < 30; k++) step(5'b00001, 1'b1);
    for (int k = 0; k < 40; k++) step(5'b0, 1'b1);
    total++;
    if (hs - n0 !== 1 || hs_code[$] !== 3'd1) begin
      bad++;
      $display("FAIL held_through_reset: handshakes %0d last code %0d, want 1 and 1", hs - n0, hs_code[$]);
    end
  endtask

  task automatic test_single_press();
    int n0, t_valid;
    align();
    n0 = hs;
    t_valid = -1;
    for (int k = 1; k <= 30; k++) begin
      step(5'b00100, 1'b1);
      if (k == 5) begin
        total++;
        if (btn_level !== 5'b0) begin
          bad++; $display("FAIL debounce_early: level %b want 00000", btn_level);
        end
      end
      if (k == 6) begin
        total++;
        if (btn_level !== 5'b00100) begin
          bad++; $display("FAIL debounce_latency: level %b want 00100", btn_level);
        end
      end
      if (k == 21) begin
        total++;
        if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
          bad++; $display("FAIL handshake_clear: valid %b code %0d want 0 0", cmd_valid, cmd_code);
        end
      end
      if (cmd_valid && t_valid < 0) t_valid = k;
    end
    for (int k = 0; k < 30; k++) step(5'b0, 1'b1);
    total++;
    if (t_valid !== 20) begin
      bad++; $display("FAIL issue_latency: valid at cycle %0d want 20", t_valid);
    end
    total++;
    if (hs - n0 !== 1 || hs_code[$] !== 3'd2) begin
      bad++; $display("FAIL single_press: handshakes %0d code %0d want 1 and 2", hs - n0, hs_code[$]);
    end
  endtask

  task automatic test_bounce();
    int n0;
    bit seen;
    align();
    n0 = hs;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step({4'b0, 1'((k / 2) % 2)}, 1'b1);
      if (btn_level !== 5'b0) seen = 1;
    end
    for (int k = 0; k < 30; k++) begin
      step(5'b0, 1'b1);
      if (btn_level !== 5'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL bounce_level: level rose, want it to stay 00000");
    end
    total++;
    if (hs - n0 !== 0) begin
      bad++; $display("FAIL bounce_cmd: handshakes %0d want 0", hs - n0);
    end
  endtask

  task automatic test_priority();
    int n0;
    align();
    n0 = hs;
    for (int k = 0; k < 45; k++) step(5'b01010, 1'b1);
    for (int k = 0; k < 40; k++) step(5'b0, 1'b1);
    total++;
    if (hs - n0 !== 2) begin
      bad++; $display("FAIL priority_count: handshakes %0d want 2", hs - n0);
    end else begin
      total++;
      if (hs_code[n0] !== 3'd5 || hs_code[n0+1] !== 3'd3) begin
        bad++; $display("FAIL priority_order: codes %0d,%0d want 5,3", hs_code[n0], hs_code[n0+1]);
      end
      total++;
      if (hs_frame[n0+1] - hs_frame[n0] !== 1) begin
        bad++; $display("FAIL priority_frames: frame gap %0d want 1", hs_frame[n0+1] - hs_frame[n0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n0, k;
    bit steady;
    align();
    n0 = hs;
    for (k = 0; k < 10; k++) step(5'b00100, 1'b0);
    k = 0;
    while (!cmd_valid && k < 40) begin
      step(5'b0, 1'b0);
      k++;
    end
    total++;
    if (!cmd_valid) begin
      bad++; $display("FAIL backpressure_timeout: valid %b want 1", cmd_valid);
    end
    steady = 1;
    for (int j = 0; j < 50; j++) begin
      step(5'b0, 1'b0);
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) steady = 0;
    end
    total++;
    if (!steady) begin
      bad++; $display("FAIL backpressure_hold: valid %b code %0d want 1 2", cmd_valid, cmd_code);
    end
    for (int j = 0; j < 15; j++) step(5'b0, 1'b1);
    total++;
    if (hs - n0 !== 1) begin
      bad++; $display("FAIL backpressure_handshakes: got %0d want 1", hs - n0);
    end
  endtask

  task automatic test_repeat();
    int n0, wrong;
    align();
    n0 = hs;
    for (int k = 0; k < 200; k++) step(5'b10000, 1'b1);
    for (int k = 0; k < 40; k++) step(5'b0, 1'b1);
    wrong = 0;
    for (int i = n0; i < hs; i++) if (hs_code[i] !== 3'd4) wrong++;
    total++;
    if (hs - n0 !== 4 || wrong != 0) begin
      bad++; $display("FAIL repeat_right: handshakes %0d (non-right %0d) want 4 (0)", hs - n0, wrong);
    end
    align();
    n0 = hs;
    for (int k = 0; k < 200; k++) step(5'b00010, 1'b1);
    for (int k = 0; k < 40; k++) step(5'b0, 1'b1);
    total++;
    if (hs - n0 !== 1 || hs_code[$] !== 3'd5) begin
      bad++; $display("FAIL center_no_repeat: handshakes %0d code %0d want 1 and 5", hs - n0, hs_code[$]);
    end
  endtask

  task automatic test_reset_mid_issue();
    int n0, k;
    align();
    for (k = 0; k < 10; k++) step(5'b00001, 1'b0);
    k = 0;
    while (!cmd_valid && k < 40) begin
      step(5'b0, 1'b0);
      k++;
    end
    total++;
    if (!cmd_valid) begin
      bad++; $display("FAIL mid_issue_timeout: valid %b want 1", cmd_valid);
    end
    io_button = 5'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_valid, cmd_code, busy, btn_level} !== 10'b0) begin
      bad++; $display("FAIL async_reset: got %b want 0", {cmd_valid, cmd_code, busy, btn_level});
    end
    model_reset();
    #2 rst_n = 1'b1;
    n0 = hs;
    for (int j = 0; j < 60; j++) step(5'b0, 1'b1);
    total++;
    if (hs - n0 !== 0) begin
      bad++; $display("FAIL reissue_after_reset: handshakes %0d want 0", hs - n0);
    end
  endtask

  task automatic test_random();
    int n;
    logic [4:0] b;
    int len;
    n = 0;
    while (n < 1500) begin
      b = 5'($urandom_range(0, 31));
      len = $urandom_range(1, 60);
      for (int j = 0; j < len; j++) step(b, $urandom_range(0, 3) != 0);
      n += len;
    end
    for (int j = 0; j < 60; j++) step(5'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_priority();
    test_backpressure();
    test_repeat();
    test_reset_mid_issue();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
